// File: rtl/pid_incr_ctrl_if.sv
// pid_incr_ctrl_if
//   Handshake/data bundle for the incremental PID controller.
//   master : sample source (drives clear, strobe, set point, process value, gains)
//   slave  : controller (drives o_u, o_valid, o_busy, o_sat, o_missed)
interface pid_incr_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
);
    logic                     i_clr;
    logic                     i_sample;
    logic signed [DATA_W-1:0] i_sp;
    logic signed [DATA_W-1:0] i_pv;
    logic signed [COEF_W-1:0] i_kp;
    logic signed [COEF_W-1:0] i_ki;
    logic signed [COEF_W-1:0] i_kd;
    logic signed [DATA_W-1:0] o_u;
    logic                     o_valid;
    logic                     o_busy;
    logic                     o_sat;
    logic                     o_missed;

    modport master (
        output i_clr, i_sample, i_sp, i_pv, i_kp, i_ki, i_kd,
        input  o_u, o_valid, o_busy, o_sat, o_missed
    );

    modport slave (
        input  i_clr, i_sample, i_sp, i_pv, i_kp, i_ki, i_kd,
        output o_u, o_valid, o_busy, o_sat, o_missed
    );
endinterface

// File: rtl/pid_incr_ctrl.sv
// pid_incr_ctrl
//   Velocity-form PID: u += (kp*d1 + ki*e0 + kd*d2) >>> FRAC_BITS, clamped to
//   [OUT_MIN, OUT_MAX]. One shared registered signed multiplier, fixed 8-state
//   sequence, result pulses o_valid 7 edges after the accepted strobe.
//   i_clk, i_rst : clock, async active-high reset
//   bus (slave)  : i_clr, i_sample, i_sp, i_pv, i_kp, i_ki, i_kd in;
//                  o_u, o_valid, o_busy, o_sat, o_missed out
module pid_incr_ctrl #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 0,
    parameter int OUT_MIN   = -32768,
    parameter int OUT_MAX   = 32767,
    parameter int OUT_INIT  = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pid_incr_ctrl_if.slave bus
);
    localparam int E0_W   = DATA_W + 1;
    localparam int D1_W   = DATA_W + 2;
    localparam int D2_W   = DATA_W + 3;
    localparam int PROD_W = COEF_W + D2_W;

    localparam logic signed [ACC_W:0]    L_MAX  = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [ACC_W:0]    L_MIN  = (ACC_W+1)'(OUT_MIN);
    localparam logic signed [DATA_W-1:0] L_INIT = DATA_W'(OUT_INIT);

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_ACC, S_SUM, S_DONE
    } state_t;

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_sp, r_pv;
    logic signed [COEF_W-1:0] r_kp, r_ki, r_kd;
    logic signed [E0_W-1:0]   r_e0, r_e1, r_e2;
    logic signed [D1_W-1:0]   r_d1;
    logic signed [D2_W-1:0]   r_d2;
    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_u_prev, r_u_new, r_u;
    logic                     r_sat_new, r_sat, r_valid, r_busy, r_missed;

    logic signed [E0_W-1:0]   w_e0;
    logic signed [D1_W-1:0]   w_d1;
    logic signed [D2_W-1:0]   w_d2;
    logic signed [D2_W-1:0]   w_ma;
    logic signed [COEF_W-1:0] w_mb;
    logic signed [PROD_W-1:0] w_ma_x, w_mb_x, w_prod;
    logic signed [ACC_W-1:0]  w_prod_x, w_shift;
    logic signed [ACC_W:0]    w_sum;
    logic signed [DATA_W-1:0] w_u_clamp;
    logic                     w_clamped;

    // Error terms widened one bit per subtraction so nothing can wrap.
    assign w_e0 = {r_sp[DATA_W-1], r_sp} - {r_pv[DATA_W-1], r_pv};
    assign w_d1 = {w_e0[E0_W-1], w_e0} - {r_e1[E0_W-1], r_e1};
    assign w_d2 = {{2{w_e0[E0_W-1]}}, w_e0} - {r_e1[E0_W-1], r_e1, 1'b0}
                + {{2{r_e2[E0_W-1]}}, r_e2};

    // Multiplier operand select; zero outside the three issue states.
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_state)
            S_MP: begin w_ma = {r_d1[D1_W-1], r_d1};         w_mb = r_kp; end
            S_MI: begin w_ma = {{2{r_e0[E0_W-1]}}, r_e0};    w_mb = r_ki; end
            S_MD: begin w_ma = r_d2;                         w_mb = r_kd; end
            default: ;
        endcase
    end

    assign w_ma_x   = {{COEF_W{w_ma[D2_W-1]}}, w_ma};
    assign w_mb_x   = {{D2_W{w_mb[COEF_W-1]}}, w_mb};
    assign w_prod   = w_ma_x * w_mb_x;
    assign w_prod_x = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
    assign w_shift  = r_acc >>> FRAC_BITS;
    assign w_sum    = {w_shift[ACC_W-1], w_shift}
                    + {{(ACC_W+1-DATA_W){r_u_prev[DATA_W-1]}}, r_u_prev};

    always_comb begin
        w_u_clamp = w_sum[DATA_W-1:0];
        w_clamped = 1'b0;
        if (w_sum > L_MAX) begin
            w_u_clamp = L_MAX[DATA_W-1:0];
            w_clamped = 1'b1;
        end else if (w_sum < L_MIN) begin
            w_u_clamp = L_MIN[DATA_W-1:0];
            w_clamped = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_sp      <= '0;
            r_pv      <= '0;
            r_kp      <= '0;
            r_ki      <= '0;
            r_kd      <= '0;
            r_e0      <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_u_prev  <= L_INIT;
            r_u_new   <= L_INIT;
            r_u       <= L_INIT;
            r_sat_new <= 1'b0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_missed  <= 1'b0;
        end else if (bus.i_clr) begin
            r_state  <= S_IDLE;
            r_e1     <= '0;
            r_e2     <= '0;
            r_u_prev <= L_INIT;
            r_u      <= L_INIT;
            r_sat    <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_prod  <= w_prod;
            // The o_valid cycle is still busy, so a strobe there is also missed.
            if (bus.i_sample && (r_state != S_IDLE || r_busy))
                r_missed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (bus.i_sample) begin
                        r_sp    <= bus.i_sp;
                        r_pv    <= bus.i_pv;
                        r_kp    <= bus.i_kp;
                        r_ki    <= bus.i_ki;
                        r_kd    <= bus.i_kd;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    r_busy  <= 1'b1;
                    r_e0    <= w_e0;
                    r_d1    <= w_d1;
                    r_d2    <= w_d2;
                    r_state <= S_MP;
                end
                S_MP:  r_state <= S_MI;
                S_MI: begin
                    r_acc   <= w_prod_x;
                    r_state <= S_MD;
                end
                S_MD: begin
                    r_acc   <= r_acc + w_prod_x;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_acc   <= r_acc + w_prod_x;
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    r_u_new   <= w_u_clamp;
                    r_sat_new <= w_clamped;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_u      <= r_u_new;
                    r_sat    <= r_sat_new;
                    r_u_prev <= r_u_new;   // clamped value: no windup past the limit
                    r_valid  <= 1'b1;
                    r_e2     <= r_e1;
                    r_e1     <= r_e0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_u      = r_u;
    assign bus.o_valid  = r_valid;
    assign bus.o_busy   = r_busy;
    assign bus.o_sat    = r_sat;
    assign bus.o_missed = r_missed;
endmodule

// File: tb/tb_pid_incr_ctrl.sv
// tb_pid_incr_ctrl
//   Three controller instances: A default, B clamped to +/-1000,
//   C with FRAC_BITS=4 and OUT_MIN=-1000. Stimulus pushes the expected
//   result and its arrival cycle; per-instance monitors pop on o_valid.
module tb_pid_incr_ctrl;
    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int u;
        bit sat;
        int c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    pid_incr_ctrl_if #(.DATA_W(DW), .COEF_W(CW)) bA ();
    pid_incr_ctrl_if #(.DATA_W(DW), .COEF_W(CW)) bB ();
    pid_incr_ctrl_if #(.DATA_W(DW), .COEF_W(CW)) bC ();

    pid_incr_ctrl #(.DATA_W(DW), .COEF_W(CW)) uA (
        .i_clk(clk), .i_rst(rst), .bus(bA)
    );
    pid_incr_ctrl #(.DATA_W(DW), .COEF_W(CW), .OUT_MIN(-1000), .OUT_MAX(1000)) uB (
        .i_clk(clk), .i_rst(rst), .bus(bB)
    );
    pid_incr_ctrl #(.DATA_W(DW), .COEF_W(CW), .FRAC_BITS(4), .OUT_MIN(-1000)) uC (
        .i_clk(clk), .i_rst(rst), .bus(bC)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon_cmp(input string nm, input int u, input bit sat, input exp_t e);
        chk({nm, " o_u"}, u, e.u);
        chk({nm, " o_sat"}, int'(sat), int'(e.sat));
        chk({nm, " o_valid cycle"}, cyc, e.c);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bA.o_valid) begin
            if (qa.size() == 0) chk("A unexpected o_valid", 1, 0);
            else begin e = qa.pop_front(); mon_cmp("A", int'(bA.o_u), bA.o_sat, e); end
        end
        if (bB.o_valid) begin
            if (qb.size() == 0) chk("B unexpected o_valid", 1, 0);
            else begin e = qb.pop_front(); mon_cmp("B", int'(bB.o_u), bB.o_sat, e); end
        end
        if (bC.o_valid) begin
            if (qc.size() == 0) chk("C unexpected o_valid", 1, 0);
            else begin e = qc.pop_front(); mon_cmp("C", int'(bC.o_u), bC.o_sat, e); end
        end
    end

    // Called just after a negedge; leaves control 1 time unit after the sampling edge.
    task automatic strobe(input int which, input int sp, input int pv, input int kp,
                          input int ki, input int kd, input int eu, input bit esat,
                          input bit push);
        exp_t e;
        bA.i_sp = DW'(sp); bA.i_pv = DW'(pv);
        bA.i_kp = CW'(kp); bA.i_ki = CW'(ki); bA.i_kd = CW'(kd);
        bB.i_sp = DW'(sp); bB.i_pv = DW'(pv);
        bB.i_kp = CW'(kp); bB.i_ki = CW'(ki); bB.i_kd = CW'(kd);
        bC.i_sp = DW'(sp); bC.i_pv = DW'(pv);
        bC.i_kp = CW'(kp); bC.i_ki = CW'(ki); bC.i_kd = CW'(kd);
        e.u = eu; e.sat = esat; e.c = cyc + 8;
        case (which)
            0: begin bA.i_sample = 1'b1; if (push) qa.push_back(e); end
            1: begin bB.i_sample = 1'b1; if (push) qb.push_back(e); end
            default: begin bC.i_sample = 1'b1; if (push) qc.push_back(e); end
        endcase
        @(posedge clk);
        #1;
        bA.i_sample = 1'b0; bB.i_sample = 1'b0; bC.i_sample = 1'b0;
    endtask

    task automatic clr(input int which);
        case (which)
            0: bA.i_clr = 1'b1;
            1: bB.i_clr = 1'b1;
            default: bC.i_clr = 1'b1;
        endcase
        @(posedge clk);
        #1;
        bA.i_clr = 1'b0; bB.i_clr = 1'b0; bC.i_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        bA.i_clr = 1'b0; bA.i_sample = 1'b0; bA.i_sp = '0; bA.i_pv = '0;
        bA.i_kp = '0; bA.i_ki = '0; bA.i_kd = '0;
        bB.i_clr = 1'b0; bB.i_sample = 1'b0; bB.i_sp = '0; bB.i_pv = '0;
        bB.i_kp = '0; bB.i_ki = '0; bB.i_kd = '0;
        bC.i_clr = 1'b0; bC.i_sample = 1'b0; bC.i_sp = '0; bC.i_pv = '0;
        bC.i_kp = '0; bC.i_ki = '0; bC.i_kd = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset o_u", int'(bA.o_u), 0);
        chk("reset o_valid", int'(bA.o_valid), 0);
        chk("reset o_busy", int'(bA.o_busy), 0);
        chk("reset o_sat", int'(bA.o_sat), 0);
        chk("reset o_missed", int'(bA.o_missed), 0);
        rst = 1'b0;
        @(negedge clk);

        // kp=2 ki=1: 0+200+100 = 300, then d1=0 d2=-100 -> +100 = 400
        strobe(0, 100, 0, 2, 1, 0, 300, 1'b0, 1'b1); idle();
        strobe(0, 100, 0, 2, 1, 0, 400, 1'b0, 1'b1); idle();

        clr(0);
        chk("A clr o_u", int'(bA.o_u), 0);
        chk("A clr o_sat", int'(bA.o_sat), 0);

        // kd only: d2 = 100, -100, 0
        strobe(0, 100, 0, 0, 0, 1, 100, 1'b0, 1'b1); idle();
        strobe(0, 100, 0, 0, 0, 1,   0, 1'b0, 1'b1); idle();
        strobe(0, 100, 0, 0, 0, 1,   0, 1'b0, 1'b1); idle();

        // B: positive clamp, no windup, then negative clamp
        strobe(1, 100, 0, 0, 100, 0, 1000, 1'b1, 1'b1); idle();
        strobe(1,   0, 0, 0, 100, 0, 1000, 1'b0, 1'b1); idle();
        clr(1);
        strobe(1, 0, 50, 0,   1, 0,   -50, 1'b0, 1'b1); idle();
        strobe(1, 0, 50, 0, 100, 0, -1000, 1'b1, 1'b1); idle();

        // C: -800 >>> 4 = -50, then -50 >>> 4 = -4 (floor) -> -54
        strobe(2, 0, 50, 0, 16, 0, -50, 1'b0, 1'b1); idle();
        strobe(2, 0, 50, 0,  1, 0, -54, 1'b0, 1'b1); idle();

        // Strobe at k and k+3 with changed data: single result from k's inputs
        clr(0);
        strobe(0, 100, 0, 2, 1, 0, 300, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        bA.i_sp = 16'sd500;
        bA.i_sample = 1'b1;
        @(posedge clk);
        #1;
        bA.i_sample = 1'b0;
        chk("A busy mid-computation", int'(bA.o_busy), 1);
        idle();
        chk("A missed after k+3 strobe", int'(bA.o_missed), 1);
        chk("A busy after done", int'(bA.o_busy), 0);
        clr(0);
        chk("A clr o_missed", int'(bA.o_missed), 0);
        chk("A clr o_u after missed", int'(bA.o_u), 0);

        // Strobe during the o_valid cycle is ignored and flagged
        strobe(0, 100, 0, 2, 1, 0, 300, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !bA.o_valid; i++) @(negedge clk);
        bA.i_sample = 1'b1;
        @(posedge clk);
        #1;
        bA.i_sample = 1'b0;
        idle();
        chk("A missed on o_valid cycle", int'(bA.o_missed), 1);

        // Reset while in MD: no result, outputs back to reset values at once
        strobe(0, 100, 0, 2, 1, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("A rst o_busy", int'(bA.o_busy), 0);
        chk("A rst o_u", int'(bA.o_u), 0);
        chk("A rst o_missed", int'(bA.o_missed), 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        strobe(0, 100, 0, 2, 1, 0, 300, 1'b0, 1'b1); idle();

        chk("A results outstanding", qa.size(), 0);
        chk("B results outstanding", qb.size(), 0);
        chk("C results outstanding", qc.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
